// File: rtl/fft_burst_frame_ctrl.sv
// Frame-level sequencer for the burst FFT/IFFT engine: takes one transform
// configuration per frame and runs it through load, engine start, calc and unload.
module fft_burst_frame_ctrl #(
    parameter int LEN_WIDTH    = 16,
    parameter int MIN_LOG2     = 3,
    parameter int CALC_TIMEOUT = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_valid_i,
    output logic                 cfg_ready_o,
    input  logic [3:0]           cfg_log2_i,
    input  logic                 cfg_inverse_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic                 s_last_i,
    output logic                 in_wr_en_o,
    output logic [LEN_WIDTH-2:0] in_wr_addr_o,
    output logic [LEN_WIDTH-1:0] dft_length_o,
    output logic [3:0]           fft_lev_limit_o,
    output logic                 dft_mode_o,
    output logic                 fft_idone_o,
    input  logic                 fft_cdone_i,
    output logic                 o_rd_enable_o,
    input  logic                 m_ready_i,
    output logic                 busy_o,
    output logic                 frame_done_o,
    output logic                 err_cfg_o,
    output logic                 err_len_o,
    output logic                 err_timeout_o
);

    // state  | meaning
    // IDLE   | waiting for a configuration handshake
    // LOAD   | accepting N input samples into the engine RAM
    // START  | one-cycle engine start pulse
    // CALC   | waiting for engine completion, watchdog running
    // UNLOAD | stepping N results out under downstream backpressure
    // DONE   | one-cycle frame completion pulse
    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_CALC, S_UNLOAD, S_DONE
    } state_t;

    localparam int WD_W = (CALC_TIMEOUT > 1) ? $clog2(CALC_TIMEOUT) : 1;

    state_t                 state_q;
    logic [LEN_WIDTH-1:0]   n_q;
    logic [LEN_WIDTH-1:0]   load_cnt_q;
    logic [LEN_WIDTH-1:0]   unload_cnt_q;
    logic [WD_W-1:0]        wdog_q;
    logic                   cfg_ready_q;
    logic                   s_ready_q;
    logic                   in_wr_en_q;
    logic [LEN_WIDTH-2:0]   in_wr_addr_q;
    logic [LEN_WIDTH-1:0]   dft_length_q;
    logic [3:0]             lev_q;
    logic                   mode_q;
    logic                   idone_q;
    logic                   rd_en_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic                   err_cfg_q;
    logic                   err_len_q;
    logic                   err_timeout_q;

    logic                   cfg_legal_d;
    logic [LEN_WIDTH-1:0]   n_d;

    assign cfg_legal_d = (int'(cfg_log2_i) >= MIN_LOG2) && (int'(cfg_log2_i) <= LEN_WIDTH - 1);
    assign n_d         = LEN_WIDTH'(1) << cfg_log2_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            n_q           <= '0;
            load_cnt_q    <= '0;
            unload_cnt_q  <= '0;
            wdog_q        <= '0;
            cfg_ready_q   <= 1'b0;
            s_ready_q     <= 1'b0;
            in_wr_en_q    <= 1'b0;
            in_wr_addr_q  <= '0;
            dft_length_q  <= '0;
            lev_q         <= '0;
            mode_q        <= 1'b0;
            idone_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            err_cfg_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            in_wr_en_q    <= 1'b0;
            idone_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            err_cfg_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_timeout_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    cfg_ready_q <= 1'b1;
                    if (cfg_valid_i && cfg_ready_q) begin
                        if (cfg_legal_d) begin
                            n_q          <= n_d;
                            dft_length_q <= n_d - 1'b1;
                            lev_q        <= cfg_log2_i;
                            mode_q       <= cfg_inverse_i;
                            load_cnt_q   <= '0;
                            cfg_ready_q  <= 1'b0;
                            s_ready_q    <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= S_LOAD;
                        end else begin
                            err_cfg_q <= 1'b1;
                        end
                    end
                end

                S_LOAD: begin
                    if (s_valid_i && s_ready_q) begin
                        in_wr_en_q   <= 1'b1;
                        in_wr_addr_q <= load_cnt_q[LEN_WIDTH-2:0];
                        load_cnt_q   <= load_cnt_q + 1'b1;
                        if (load_cnt_q == dft_length_q) begin
                            // missing s_last on the final sample is flagged but not fatal
                            err_len_q <= !s_last_i;
                            s_ready_q <= 1'b0;
                            idone_q   <= 1'b1;
                            state_q   <= S_START;
                        end else if (s_last_i) begin
                            err_len_q   <= 1'b1;
                            s_ready_q   <= 1'b0;
                            cfg_ready_q <= 1'b1;
                            busy_q      <= 1'b0;
                            state_q     <= S_IDLE;
                        end
                    end
                end

                S_START: begin
                    wdog_q  <= WD_W'(CALC_TIMEOUT - 1);
                    state_q <= S_CALC;
                end

                S_CALC: begin
                    // completion takes priority over a watchdog expiring in the same cycle
                    if (fft_cdone_i) begin
                        unload_cnt_q <= '0;
                        state_q      <= S_UNLOAD;
                    end else if ((CALC_TIMEOUT != 0) && (wdog_q == '0)) begin
                        err_timeout_q <= 1'b1;
                        cfg_ready_q   <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        wdog_q <= wdog_q - 1'b1;
                    end
                end

                S_UNLOAD: begin
                    if (unload_cnt_q == n_q) begin
                        frame_done_q <= 1'b1;
                        state_q      <= S_DONE;
                    end else if (m_ready_i) begin
                        rd_en_q      <= 1'b1;
                        unload_cnt_q <= unload_cnt_q + 1'b1;
                    end
                end

                S_DONE: begin
                    cfg_ready_q <= 1'b1;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end

                default: begin
                    cfg_ready_q <= 1'b0;
                    s_ready_q   <= 1'b0;
                    busy_q      <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o     = cfg_ready_q;
    assign s_ready_o       = s_ready_q;
    assign in_wr_en_o      = in_wr_en_q;
    assign in_wr_addr_o    = in_wr_addr_q;
    assign dft_length_o    = dft_length_q;
    assign fft_lev_limit_o = lev_q;
    assign dft_mode_o      = mode_q;
    assign fft_idone_o     = idone_q;
    assign o_rd_enable_o   = rd_en_q;
    assign busy_o          = busy_q;
    assign frame_done_o    = frame_done_q;
    assign err_cfg_o       = err_cfg_q;
    assign err_len_o       = err_len_q;
    assign err_timeout_o   = err_timeout_q;

endmodule

// File: tb/tb_fft_burst_frame_ctrl.sv
// Self-checking bench for fft_burst_frame_ctrl: configuration vector table,
// write-address scoreboard and hand-written multi-cycle frame sequences.
module tb_fft_burst_frame_ctrl;

    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [3:0]    cfg_log2 = '0;
    logic          cfg_inverse = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          s_last = 1'b0;
    logic          in_wr_en;
    logic [LW-2:0] in_wr_addr;
    logic [LW-1:0] dft_length;
    logic [3:0]    fft_lev_limit;
    logic          dft_mode;
    logic          fft_idone;
    logic          fft_cdone = 1'b0;
    logic          o_rd_enable;
    logic          m_ready = 1'b0;
    logic          busy;
    logic          frame_done;
    logic          err_cfg;
    logic          err_len;
    logic          err_timeout;

    fft_burst_frame_ctrl #(.LEN_WIDTH(LW), .MIN_LOG2(3), .CALC_TIMEOUT(50)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_valid_i     (cfg_valid),
        .cfg_ready_o     (cfg_ready),
        .cfg_log2_i      (cfg_log2),
        .cfg_inverse_i   (cfg_inverse),
        .s_valid_i       (s_valid),
        .s_ready_o       (s_ready),
        .s_last_i        (s_last),
        .in_wr_en_o      (in_wr_en),
        .in_wr_addr_o    (in_wr_addr),
        .dft_length_o    (dft_length),
        .fft_lev_limit_o (fft_lev_limit),
        .dft_mode_o      (dft_mode),
        .fft_idone_o     (fft_idone),
        .fft_cdone_i     (fft_cdone),
        .o_rd_enable_o   (o_rd_enable),
        .m_ready_i       (m_ready),
        .busy_o          (busy),
        .frame_done_o    (frame_done),
        .err_cfg_o       (err_cfg),
        .err_len_o       (err_len),
        .err_timeout_o   (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int log2;
        bit inv;
        bit exp_err;
        int exp_len;
    } cfg_vec_t;

    cfg_vec_t      vecs[7];
    logic [LW-2:0] wr_q[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_wr, n_idone, n_rd, n_fdone, n_ecfg, n_elen, n_eto;
    int first_rd, last_rd, fdone_cyc, idone_cyc, eto_cyc;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        n_wr = 0; n_idone = 0; n_rd = 0; n_fdone = 0;
        n_ecfg = 0; n_elen = 0; n_eto = 0;
        first_rd = -1; last_rd = -1; fdone_cyc = -1; idone_cyc = -1; eto_cyc = -1;
    endtask

    // One clock: sample registered outputs just after the edge, then return for new drive.
    task automatic tick();
        logic [LW-2:0] exp_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (in_wr_en) begin
            n_wr++;
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL wr_unexpected: got addr %0d expected no write", in_wr_addr);
            end else begin
                exp_addr = wr_q.pop_front();
                check("wr_addr", int'(in_wr_addr), int'(exp_addr));
            end
        end
        if (fft_idone) begin n_idone++; idone_cyc = cyc; end
        if (o_rd_enable) begin
            n_rd++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
        end
        if (frame_done) begin n_fdone++; fdone_cyc = cyc; end
        if (err_cfg) n_ecfg++;
        if (err_len) n_elen++;
        if (err_timeout) begin n_eto++; eto_cyc = cyc; end
    endtask

    task automatic send_cfg(input int l2, input bit inv);
        check("cfg_ready_pre", cfg_ready, 1);
        cfg_valid   = 1'b1;
        cfg_log2    = 4'(l2);
        cfg_inverse = inv;
        tick();
        cfg_valid   = 1'b0;
    endtask

    task automatic load(input int n, input int last_idx);
        for (int i = 0; i < n; i++) begin
            check("s_ready", s_ready, 1);
            if (s_ready !== 1'b1) break;
            s_valid = 1'b1;
            s_last  = (i == last_idx);
            wr_q.push_back(LW'(i) & {1'b0, {(LW-1){1'b1}}});
            tick();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_calc(input int delay);
        for (int i = 1; i < delay; i++) tick();
        fft_cdone = 1'b1;
        tick();
        fft_cdone = 1'b0;
    endtask

    task automatic unload(input bit toggle, input int exp_n);
        m_ready = 1'b1;
        for (int i = 0; i < 300 && n_fdone == 0; i++) begin
            if (toggle) m_ready = ~m_ready;
            tick();
        end
        m_ready = 1'b0;
        check("frame_done_count", n_fdone, 1);
        check("rd_count", n_rd, exp_n);
        if (!toggle) check("rd_consecutive", last_rd - first_rd + 1, exp_n);
        check("fdone_after_last_rd", fdone_cyc - last_rd, 1);
        check("done_state_busy", busy, 1);
        tick();
        check("post_done_cfg_ready", cfg_ready, 1);
        check("post_done_busy", busy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        vecs[0] = '{log2: 2,  inv: 1'b0, exp_err: 1'b1, exp_len: 0};
        vecs[1] = '{log2: 15, inv: 1'b0, exp_err: 1'b0, exp_len: 32767};
        vecs[2] = '{log2: 3,  inv: 1'b1, exp_err: 1'b0, exp_len: 7};
        vecs[3] = '{log2: 0,  inv: 1'b0, exp_err: 1'b1, exp_len: 0};
        vecs[4] = '{log2: 4,  inv: 1'b0, exp_err: 1'b0, exp_len: 15};
        vecs[5] = '{log2: 8,  inv: 1'b1, exp_err: 1'b0, exp_len: 255};
        vecs[6] = '{log2: 1,  inv: 1'b1, exp_err: 1'b1, exp_len: 0};
        clear_stats();

        // reset state
        repeat (3) tick();
        check("rst_dft_length", int'(dft_length), 0);
        check("rst_ctrl", int'({cfg_ready, s_ready, in_wr_en, in_wr_addr, fft_lev_limit, dft_mode,
                                fft_idone, o_rd_enable, busy, frame_done, err_cfg, err_len, err_timeout}), 0);
        rst_n = 1'b1;
        tick();
        check("idle_cfg_ready", cfg_ready, 1);
        check("idle_busy", busy, 0);

        // stray completion pulse while idle is ignored
        fft_cdone = 1'b1;
        tick();
        fft_cdone = 1'b0;
        tick();
        check("stray_cdone_busy", busy, 0);

        // configuration vector table
        for (int i = 0; i < 7; i++) begin
            clear_stats();
            send_cfg(vecs[i].log2, vecs[i].inv);
            check("cfg_err", err_cfg, int'(vecs[i].exp_err));
            check("cfg_busy", busy, int'(!vecs[i].exp_err));
            if (!vecs[i].exp_err) begin
                check("cfg_dft_length", int'(dft_length), vecs[i].exp_len);
                check("cfg_lev", int'(fft_lev_limit), vecs[i].log2);
                check("cfg_mode", dft_mode, int'(vecs[i].inv));
                load(1, 0);
                check("abort_err_len", err_len, 1);
                check("abort_busy", busy, 0);
                check("abort_cfg_ready", cfg_ready, 1);
                check("abort_idone", n_idone, 0);
            end else begin
                tick();
                check("bad_cfg_idle", busy, 0);
                check("bad_cfg_ready", cfg_ready, 1);
                check("bad_cfg_pulse", n_ecfg, 1);
            end
        end

        // nominal FFT frame, N=8
        clear_stats();
        send_cfg(3, 1'b0);
        check("f1_dft_length", int'(dft_length), 7);
        check("f1_lev", int'(fft_lev_limit), 3);
        check("f1_mode", dft_mode, 0);
        load(8, 7);
        check("f1_idone_now", fft_idone, 1);
        wait_calc(20);
        unload(1'b0, 8);
        check("f1_writes", n_wr, 8);
        check("f1_idone_count", n_idone, 1);
        check("f1_errors", n_ecfg + n_elen + n_eto, 0);

        // s_last on the 5th sample aborts the frame
        clear_stats();
        send_cfg(3, 1'b0);
        load(5, 4);
        check("early_last_err_len", err_len, 1);
        check("early_last_busy", busy, 0);
        check("early_last_cfg_ready", cfg_ready, 1);
        tick();
        check("early_last_no_idone", n_idone, 0);

        // missing s_last on the 8th sample: flagged, frame completes
        clear_stats();
        send_cfg(3, 1'b0);
        load(8, -1);
        check("late_last_err_len", err_len, 1);
        check("late_last_idone", fft_idone, 1);
        wait_calc(10);
        unload(1'b0, 8);
        check("late_last_err_count", n_elen, 1);

        // CALC watchdog expiry
        clear_stats();
        send_cfg(3, 1'b0);
        load(8, 7);
        for (int i = 0; i < 100 && n_eto == 0; i++) tick();
        check("timeout_seen", n_eto, 1);
        check("timeout_latency", eto_cyc - idone_cyc, 51);
        check("timeout_busy", busy, 0);
        check("timeout_cfg_ready", cfg_ready, 1);

        // completion in the very cycle the watchdog would expire
        clear_stats();
        send_cfg(3, 1'b0);
        load(8, 7);
        wait_calc(51);
        unload(1'b0, 8);
        check("cdone_wins_no_timeout", n_eto, 0);

        // reset while unloading
        clear_stats();
        send_cfg(3, 1'b0);
        load(8, 7);
        wait_calc(5);
        m_ready = 1'b1;
        repeat (3) tick();
        check("pre_rst_rd_count", n_rd, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd", o_rd_enable, 0);
        check("mid_rst_ctrl", int'({cfg_ready, s_ready, in_wr_en, in_wr_addr, fft_lev_limit, dft_mode,
                                    fft_idone, busy, frame_done, err_cfg, err_len, err_timeout}), 0);
        check("mid_rst_dft_length", int'(dft_length), 0);
        m_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_cfg_ready", cfg_ready, 1);
        check("post_rst_no_fdone", n_fdone, 0);

        // IFFT N=16 with toggling backpressure
        clear_stats();
        send_cfg(4, 1'b1);
        check("f2_dft_length", int'(dft_length), 15);
        check("f2_mode", dft_mode, 1);
        load(16, 15);
        wait_calc(7);
        unload(1'b1, 16);
        check("f2_errors", n_ecfg + n_elen + n_eto, 0);
        check("sb_empty", wr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_burst_frame_ctrl.md
Name: fft_burst_frame_ctrl

Overview:
- Frame-level sequencer for the burst FFT/IFFT engine.
- Takes one transform configuration per frame and runs the frame through LOAD, engine start, CALC and UNLOAD.
  - LOAD: writes input samples to the engine RAM.
  - Engine start: pulses fft_idone.
  - CALC: waits for fft_cdone.
  - UNLOAD: drives o_rd_enable under downstream backpressure.
- Sits between the stream-side wrapper and the FFT RAM read/address engine. Derives dft_length, fft_lev_limit and dft_mode for that engine.

Parameters:
- LEN_WIDTH, 16, width of the length/address buses; maximum transform length is 2^(LEN_WIDTH-1).
- MIN_LOG2, 3, smallest legal log2 transform length.
- CALC_TIMEOUT, 65535, maximum CALC cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cfg_valid  in  1  configuration offered
- cfg_ready  out  1  configuration accepted when cfg_valid&cfg_ready
- cfg_log2  in  4  log2 of transform length
- cfg_inverse  in  1  1 = IFFT, 0 = FFT
- s_valid  in  1  input sample valid
- s_ready  out  1  controller accepts a sample
- s_last  in  1  marks the final sample of a frame
- in_wr_en  out  1  input RAM write strobe
- in_wr_addr  out  LEN_WIDTH-1  input RAM write address
- dft_length  out  LEN_WIDTH  N-1 for the active frame
- fft_lev_limit  out  4  number of butterfly levels (= cfg_log2)
- dft_mode  out  1  latched cfg_inverse
- fft_idone  out  1  one-cycle start pulse to the engine
- fft_cdone  in  1  one-cycle engine completion pulse
- o_rd_enable  out  1  engine output read step
- m_ready  in  1  downstream can take a result sample
- busy  out  1  controller not in IDLE
- frame_done  out  1  one-cycle pulse when a frame has completed unload
- err_cfg  out  1  one-cycle pulse: illegal configuration rejected
- err_len  out  1  one-cycle pulse: s_last position mismatch
- err_timeout  out  1  one-cycle pulse: CALC watchdog expired

Behaviour:
- Reset: every output is 0; state = IDLE; counters, dft_length, fft_lev_limit and dft_mode are cleared. Reset mid-frame aborts the frame immediately with no pulses.
- States: IDLE, LOAD, START, CALC, UNLOAD, DONE. All outputs are registered.
- IDLE: cfg_ready=1.
  - On cfg handshake with MIN_LOG2 <= cfg_log2 <= LEN_WIDTH-1: latch N=2^cfg_log2, dft_length=N-1, fft_lev_limit=cfg_log2, dft_mode=cfg_inverse. Go to LOAD next cycle.
  - On an out-of-range cfg_log2: pulse err_cfg on the following cycle and stay in IDLE.
- LOAD: s_ready=1. Each s_valid&s_ready asserts in_wr_en with in_wr_addr = load count on the next cycle. The load count starts at 0 and increments by 1 per accepted sample.
  - Sample N-1 accepted: go to START. If s_last=0 on that sample, pulse err_len but the frame continues.
  - s_last=1 on a sample with index < N-1: pulse err_len, discard the frame, return to IDLE (no fft_idone).
- START: fft_idone=1 for exactly one cycle, then go to CALC. s_ready=0 from START through DONE.
- CALC: wait for fft_cdone.
  - The watchdog counts CALC cycles. If it reaches CALC_TIMEOUT (non-zero) without fft_cdone: pulse err_timeout, return to IDLE.
  - If fft_cdone and the timeout occur in the same cycle, fft_cdone wins.
  - fft_cdone seen in any state other than CALC is ignored.
- UNLOAD: o_rd_enable = m_ready, combinationally gated through a register stage so it is asserted the cycle after m_ready is high.
  - The unload counter increments on each o_rd_enable.
  - After N assertions, o_rd_enable drops in the following cycle and the state goes to DONE. It never exceeds N assertions.
  - m_ready low stalls the counter without loss.
- DONE: frame_done=1 for one cycle, then IDLE. cfg_ready rises in the cycle after DONE. Back-to-back frames therefore have 2 cycles of overhead.
- busy=1 in every state except IDLE.
- Width rules: in_wr_addr is the low LEN_WIDTH-1 bits of the load count. The load and unload counters are LEN_WIDTH wide so that N = 2^(LEN_WIDTH-1) does not wrap.

Test Plan:
- Reset during UNLOAD: all outputs 0 immediately, busy=0; a new cfg is accepted cleanly after rst_n rises.
- cfg_log2=3, FFT, 8 samples with s_last on the 8th, fft_cdone 20 cycles after fft_idone, m_ready=1: expect
  - in_wr_addr sequence 0..7;
  - dft_length=7, fft_lev_limit=3, dft_mode=0;
  - a single fft_idone pulse;
  - exactly 8 consecutive o_rd_enable;
  - frame_done once; no error pulses.
- cfg_log2=4, IFFT, m_ready toggling every cycle during UNLOAD: exactly 16 o_rd_enable total, dft_mode=1, frame_done only after the 16th.
- cfg_log2=2, then cfg_log2=15: err_cfg pulse and state stays IDLE for the first; the second is accepted with dft_length=32767.
- cfg_log2=3, s_last on the 5th sample: err_len pulse, no fft_idone, busy=0, cfg_ready=1. A repeat with no s_last on the 8th sample gives err_len and the frame completes normally.
- CALC_TIMEOUT=50, no fft_cdone: err_timeout 50 cycles after entering CALC, then IDLE. Retry with fft_cdone arriving in the timeout cycle: no err_timeout, UNLOAD proceeds.
